// File: rtl/axi_protocol_converter_pkg.sv
// Shared definitions for the AXI protocol converter: response codes and
// AXI3 burst limits used by the split/merge datapaths.
package axi_protocol_converter_pkg;

   // AXI read/write response encodings.
   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   // Longest burst AXI3 allows, in beats.
   localparam int unsigned C_AXI3_MAX_LEN = 16;

   // Width of the AXLEN field that encodes an AXI3 burst (beats minus 1).
   localparam int unsigned C_AXI3_LEN_WIDTH = $clog2(C_AXI3_MAX_LEN);

   // Width of the per-burst beat counter in the merge path.
   localparam int unsigned C_BEAT_CNT_WIDTH = 8;

endpackage

// File: rtl/axi_protocol_converter_r_axi3_merge_if.sv
// AXI read-data (R) channel bundle. The master modport is the side that
// produces beats, the slave modport is the side that accepts them.
interface axi_protocol_converter_r_axi3_merge_if #(
   parameter int unsigned ID_WIDTH    = 1,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned RUSER_WIDTH = 1
);
   logic [ID_WIDTH-1:0]    rid;
   logic [DATA_WIDTH-1:0]  rdata;
   logic [1:0]             rresp;
   logic                   rlast;
   logic [RUSER_WIDTH-1:0] ruser;
   logic                   rvalid;
   logic                   rready;

   modport master (
      output rid, rdata, rresp, rlast, ruser, rvalid,
      input  rready
   );

   modport slave (
      input  rid, rdata, rresp, rlast, ruser, rvalid,
      output rready
   );
endinterface

// File: rtl/axi_protocol_converter_r_skid.sv
// Generic 2-entry valid/ready skid buffer: an output register backed by a
// single skid register. One cycle of latency, full throughput, and the
// input side stalls only once both entries hold a beat.
module axi_protocol_converter_r_skid #(
   parameter int unsigned C_WIDTH = 8
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [C_WIDTH-1:0] in_payload,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [C_WIDTH-1:0] out_payload
);

   logic               out_vld;
   logic               skid_vld;
   logic [C_WIDTH-1:0] out_q;
   logic [C_WIDTH-1:0] skid_q;
   logic               push;
   logic               drain;

   assign in_ready    = ~skid_vld;
   assign push        = in_valid & in_ready;
   assign drain       = out_vld & out_ready;
   assign out_valid   = out_vld;
   assign out_payload = out_q;

   // Output register refills from skid first (ordering), else from the input.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (!out_vld || drain) begin
         if (skid_vld) begin
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
         end else begin
            out_vld <= push;
            if (push) begin
               out_q <= in_payload;
            end
         end
      end else if (push) begin
         skid_q   <= in_payload;
         skid_vld <= 1'b1;
      end
   end

endmodule

// File: rtl/axi_protocol_converter_r_axi3_merge.sv
// AXI3-to-AXI4 R-channel merge. Each command describes one AXI3 burst of an
// AXI4 burst split by the AR path; returning AXI3 beats are forwarded with
// RLAST suppressed on non-final splits, beat counts are checked against the
// command, and the slave side is driven through a 2-entry skid buffer.
module axi_protocol_converter_r_axi3_merge
   import axi_protocol_converter_pkg::*;
#(
   parameter              C_FAMILY                    = "none",
   parameter int unsigned C_AXI_ID_WIDTH              = 1,
   parameter int unsigned C_AXI_DATA_WIDTH            = 32,
   parameter int unsigned C_AXI_SUPPORTS_USER_SIGNALS = 0,
   parameter int unsigned C_AXI_RUSER_WIDTH           = 1,
   parameter int unsigned C_SUPPORT_SPLITTING         = 1,
   parameter int unsigned C_SUPPORT_BURSTS            = 1
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic                        cmd_valid,
   input  logic                        cmd_split,
   input  logic [C_AXI3_LEN_WIDTH-1:0] cmd_length,
   output logic                        cmd_ready,
   output logic                        length_error,
   axi_protocol_converter_r_axi3_merge_if.master S_AXI,
   axi_protocol_converter_r_axi3_merge_if.slave  M_AXI
);

   localparam int unsigned PAYLOAD_W =
      C_AXI_ID_WIDTH + C_AXI_DATA_WIDTH + 2 + 1 + C_AXI_RUSER_WIDTH;
   localparam unused_family = C_FAMILY;

   logic                         skid_in_ready;
   logic                         pop;
   logic                         m_last;
   logic                         s_last;
   logic [C_AXI_RUSER_WIDTH-1:0] ruser_in;
   logic [PAYLOAD_W-1:0]         in_payload;
   logic [PAYLOAD_W-1:0]         out_payload;
   logic [C_BEAT_CNT_WIDTH-1:0]  beat_cnt;
   logic                         cnt_at_len;
   logic                         len_mismatch;
   logic                         unused_bits;

   assign M_AXI.rready = cmd_valid & skid_in_ready & ~ARESET;
   assign pop          = M_AXI.rvalid & M_AXI.rready;

   generate
      if (C_AXI_SUPPORTS_USER_SIGNALS != 0) begin : g_user
         assign ruser_in = M_AXI.ruser;
      end else begin : g_no_user
         assign ruser_in = '0;
      end

      if (C_SUPPORT_SPLITTING != 0) begin : g_split
         assign s_last = M_AXI.rlast & ~cmd_split;
      end else begin : g_no_split
         assign s_last = M_AXI.rlast;
      end

      if (C_SUPPORT_BURSTS != 0) begin : g_bursts
         assign m_last = M_AXI.rlast;
      end else begin : g_single
         assign m_last = 1'b1;
      end
   endgenerate

   assign cmd_ready  = pop & m_last;
   assign in_payload = {M_AXI.rid, M_AXI.rdata, M_AXI.rresp, s_last, ruser_in};

   // Only the low AXLEN bits of the counter take part in the length check.
   assign cnt_at_len   = (beat_cnt[C_AXI3_LEN_WIDTH-1:0] == cmd_length);
   assign len_mismatch = (m_last & ~cnt_at_len) | (~M_AXI.rlast & cnt_at_len);

   assign unused_bits = ^{beat_cnt[C_BEAT_CNT_WIDTH-1:C_AXI3_LEN_WIDTH], M_AXI.ruser};

   // Beat counter per AXI3 burst and sticky length-error flag.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         beat_cnt     <= '0;
         length_error <= 1'b0;
      end else if (pop) begin
         if (m_last) begin
            beat_cnt <= '0;
         end else begin
            beat_cnt <= beat_cnt + C_BEAT_CNT_WIDTH'(1);
         end
         if (len_mismatch) begin
            length_error <= 1'b1;
         end
      end
   end

   axi_protocol_converter_r_skid #(
      .C_WIDTH (PAYLOAD_W)
   ) u_skid (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .in_valid    (pop),
      .in_ready    (skid_in_ready),
      .in_payload  (in_payload),
      .out_valid   (S_AXI.rvalid),
      .out_ready   (S_AXI.rready),
      .out_payload (out_payload)
   );

   assign {S_AXI.rid, S_AXI.rdata, S_AXI.rresp, S_AXI.rlast, S_AXI.ruser} = out_payload;

endmodule

// File: tb/tb_axi_protocol_converter_r_axi3_merge.sv
// Self-checking bench for the AXI3-to-AXI4 R-channel merge. Beats and
// commands are queued per scenario; a scoreboard of expected S-side beats
// and buffer occupancy is maintained from the channel rules.
module tb_axi_protocol_converter_r_axi3_merge;
   import axi_protocol_converter_pkg::*;

   localparam int ID_W = 4;
   localparam int DW   = 32;
   localparam int UW   = 2;

   logic       ACLK = 1'b0;
   logic       ARESET;
   logic       cmd_valid;
   logic       cmd_split;
   logic [3:0] cmd_length;
   logic       cmd_ready;
   logic       length_error;

   axi_protocol_converter_r_axi3_merge_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DW), .RUSER_WIDTH(UW)) s_if ();
   axi_protocol_converter_r_axi3_merge_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DW), .RUSER_WIDTH(UW)) m_if ();

   always #5 ACLK = ~ACLK;

   axi_protocol_converter_r_axi3_merge #(
      .C_FAMILY                    ("none"),
      .C_AXI_ID_WIDTH              (ID_W),
      .C_AXI_DATA_WIDTH            (DW),
      .C_AXI_SUPPORTS_USER_SIGNALS (1),
      .C_AXI_RUSER_WIDTH           (UW),
      .C_SUPPORT_SPLITTING         (1),
      .C_SUPPORT_BURSTS            (1)
   ) u_dut (
      .ACLK         (ACLK),
      .ARESET       (ARESET),
      .cmd_valid    (cmd_valid),
      .cmd_split    (cmd_split),
      .cmd_length   (cmd_length),
      .cmd_ready    (cmd_ready),
      .length_error (length_error),
      .S_AXI        (s_if),
      .M_AXI        (m_if)
   );

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [DW-1:0]   data;
      logic [1:0]      resp;
      logic            last;
      logic [UW-1:0]   user;
   } beat_t;

   typedef struct packed {
      logic       split;
      logic [3:0] len;
   } cmd_t;

   beat_t mq[$];
   beat_t exp_q[$];
   cmd_t  cq[$];

   int pass_cnt  = 0;
   int total_cnt = 0;
   int burst_beats = 0;
   bit model_err = 1'b0;
   int n_sbeats, n_slast, n_cmdrdy;
   int rready_mode = 0;
   bit mvalid_rand = 1'b0;
   bit cmd_block   = 1'b0;
   bit m_vld_hold  = 1'b0;
   int stall_from  = 0;
   int stall_len   = 0;
   int cyc         = 0;

   task automatic clear_stats();
      n_sbeats = 0; n_slast = 0; n_cmdrdy = 0; cyc = 0; stall_len = 0;
   endtask

   task automatic add_burst(input int nbeats, input bit split, input int len, input logic [ID_W-1:0] id);
      beat_t b;
      cmd_t c;
      axi_resp_e r;
      c.split = split;
      c.len   = 4'(len);
      cq.push_back(c);
      for (int i = 1; i <= nbeats; i++) begin
         r      = axi_resp_e'($urandom_range(0, 3));
         b.id   = id;
         b.data = $urandom;
         b.resp = r;
         b.last = (i == nbeats);
         b.user = UW'($urandom_range(0, 3));
         mq.push_back(b);
      end
   endtask

   task automatic drive();
      cmd_valid = (cq.size() > 0) && !cmd_block;
      if (cq.size() > 0) begin
         cmd_split  = cq[0].split;
         cmd_length = cq[0].len;
      end else begin
         cmd_split  = 1'b0;
         cmd_length = '0;
      end
      if (mq.size() == 0) begin
         m_if.rvalid = 1'b0;
         {m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, m_if.ruser} = '0;
      end else begin
         if (m_vld_hold)       m_if.rvalid = 1'b1;
         else if (mvalid_rand) m_if.rvalid = ($urandom_range(0, 3) != 0);
         else                  m_if.rvalid = 1'b1;
         m_if.rid   = mq[0].id;
         m_if.rdata = mq[0].data;
         m_if.rresp = mq[0].resp;
         m_if.rlast = mq[0].last;
         m_if.ruser = mq[0].user;
      end
      if (cyc >= stall_from && cyc < stall_from + stall_len) s_if.rready = 1'b0;
      else if (rready_mode == 1)                              s_if.rready = 1'($urandom_range(0, 1));
      else                                                    s_if.rready = 1'b1;
   endtask

   // One clock cycle: sample #1 after the negedge, update model, advance.
   task automatic tick();
      logic  m_acc, s_acc, exp_mr, exp_cr;
      beat_t sb, eb;
      cmd_t  c;
      #1;
      exp_mr = cmd_valid && (exp_q.size() < 2);
      total_cnt++;
      if (m_if.rready !== exp_mr) $display("FAIL m_rready cyc=%0d got %b exp %b", cyc, m_if.rready, exp_mr);
      else pass_cnt++;
      total_cnt++;
      if (s_if.rvalid !== (exp_q.size() > 0)) $display("FAIL s_rvalid cyc=%0d got %b exp %b", cyc, s_if.rvalid, exp_q.size() > 0);
      else pass_cnt++;
      total_cnt++;
      if (length_error !== model_err) $display("FAIL length_error cyc=%0d got %b exp %b", cyc, length_error, model_err);
      else pass_cnt++;
      m_acc  = m_if.rvalid & m_if.rready;
      s_acc  = s_if.rvalid & s_if.rready;
      exp_cr = m_acc & m_if.rlast;
      total_cnt++;
      if (cmd_ready !== exp_cr) $display("FAIL cmd_ready cyc=%0d got %b exp %b", cyc, cmd_ready, exp_cr);
      else pass_cnt++;
      if (cmd_ready === 1'b1) n_cmdrdy++;
      if (s_acc === 1'b1) begin
         sb = {s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast, s_if.ruser};
         total_cnt++;
         if (exp_q.size() == 0) $display("FAIL s_beat unexpected got %h exp none", sb);
         else begin
            eb = exp_q.pop_front();
            if (sb !== eb) $display("FAIL s_beat got %h exp %h", sb, eb);
            else pass_cnt++;
         end
         n_sbeats++;
         if (s_if.rlast === 1'b1) n_slast++;
      end
      if (m_acc === 1'b1 && mq.size() > 0) begin
         eb = mq.pop_front();
         if (cq.size() > 0) c = cq[0];
         else c = '0;
         burst_beats++;
         if (eb.last && ((burst_beats - 1) % 16) != int'(c.len))  model_err = 1'b1;
         if (!eb.last && ((burst_beats - 1) % 16) == int'(c.len)) model_err = 1'b1;
         eb.last = eb.last & ~c.split;
         exp_q.push_back(eb);
         if (mq.size() >= 0 && m_if.rlast) begin
            burst_beats = 0;
            if (cq.size() > 0) void'(cq.pop_front());
         end
      end
      m_vld_hold = m_if.rvalid && !m_acc;
      @(posedge ACLK);
      @(negedge ACLK);
      cyc++;
      drive();
   endtask

   task automatic run(input int max_cyc, input string name);
      int n = 0;
      while ((mq.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
         tick();
         n++;
      end
      total_cnt++;
      if (mq.size() > 0 || exp_q.size() > 0)
         $display("FAIL %s timeout got %0d pending exp 0", name, mq.size() + exp_q.size());
      else pass_cnt++;
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      total_cnt++;
      if (got != exp) $display("FAIL %s got %0d exp %0d", name, got, exp);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      drive();
      cmd_valid = 1'b1;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      #1;
      check_int("reset_s_rvalid", int'(s_if.rvalid), 0);
      check_int("reset_m_rready", int'(m_if.rready), 0);
      check_int("reset_cmd_ready", int'(cmd_ready), 0);
      check_int("reset_length_error", int'(length_error), 0);
      ARESET = 1'b0;
      drive();
   endtask

   task automatic test_unsplit();
      clear_stats();
      add_burst(4, 1'b0, 3, 4'h3);
      drive();
      run(50, "unsplit");
      check_int("unsplit_beats", n_sbeats, 4);
      check_int("unsplit_last", n_slast, 1);
      check_int("unsplit_cmd_ready", n_cmdrdy, 1);
      check_int("unsplit_err", int'(length_error), 0);
   endtask

   task automatic test_split();
      clear_stats();
      add_burst(16, 1'b1, 15, 4'hA);
      add_burst(4, 1'b0, 3, 4'hA);
      drive();
      run(100, "split");
      check_int("split_beats", n_sbeats, 20);
      check_int("split_last", n_slast, 1);
      check_int("split_cmd_ready", n_cmdrdy, 2);
   endtask

   task automatic test_backpressure();
      clear_stats();
      stall_from = 3;
      stall_len  = 5;
      add_burst(8, 1'b0, 7, 4'h5);
      drive();
      run(100, "backpressure");
      check_int("bp_beats", n_sbeats, 8);
      stall_len = 0;
   endtask

   task automatic test_no_cmd();
      clear_stats();
      add_burst(4, 1'b0, 3, 4'h1);
      cmd_block = 1'b1;
      drive();
      repeat (10) tick();
      check_int("nocmd_no_out", n_sbeats, 0);
      cmd_block = 1'b0;
      drive();
      #1;
      check_int("nocmd_first_accept", int'(m_if.rvalid & m_if.rready), 1);
      run(50, "no_cmd");
      check_int("nocmd_beats", n_sbeats, 4);
   endtask

   task automatic test_random();
      int total, chunk;
      logic [ID_W-1:0] id;
      clear_stats();
      rready_mode = 1;
      mvalid_rand = 1'b1;
      total = 0;
      for (int b = 0; b < 6; b++) begin
         int left;
         left = $urandom_range(1, 40);
         id   = ID_W'($urandom);
         total += left;
         while (left > 0) begin
            chunk = (left > 16) ? 16 : left;
            left -= chunk;
            add_burst(chunk, left > 0, chunk - 1, id);
         end
      end
      drive();
      run(3000, "random");
      check_int("random_beats", n_sbeats, total);
      check_int("random_last", n_slast, 6);
      rready_mode = 0;
      mvalid_rand = 1'b0;
      drive();
   endtask

   task automatic test_length_mismatch();
      clear_stats();
      add_burst(2, 1'b0, 3, 4'h7);
      drive();
      run(50, "mismatch");
      tick();
      check_int("mismatch_err_set", int'(length_error), 1);
      add_burst(4, 1'b0, 3, 4'h7);
      drive();
      run(50, "mismatch_good");
      tick();
      check_int("mismatch_err_sticky", int'(length_error), 1);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      clear_stats();
      stall_from = 0;
      stall_len  = 1000;
      add_burst(4, 1'b0, 3, 4'h9);
      drive();
      while (exp_q.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      check_int("rmid_buffered", exp_q.size(), 2);
      #1;
      check_int("rmid_m_rready_full", int'(m_if.rready), 0);
      ARESET = 1'b1;
      mq.delete(); cq.delete(); exp_q.delete();
      burst_beats = 0;
      model_err   = 1'b0;
      m_vld_hold  = 1'b0;
      drive();
      @(posedge ACLK);
      @(negedge ACLK);
      #1;
      check_int("rmid_s_rvalid", int'(s_if.rvalid), 0);
      check_int("rmid_m_rready", int'(m_if.rready), 0);
      check_int("rmid_length_error", int'(length_error), 0);
      ARESET = 1'b0;
      clear_stats();
      add_burst(4, 1'b0, 3, 4'h9);
      drive();
      run(50, "reset_mid_new");
      check_int("rmid_new_beats", n_sbeats, 4);
      check_int("rmid_new_cmd_ready", n_cmdrdy, 1);
   endtask

   task automatic test_missing_rlast();
      clear_stats();
      add_burst(3, 1'b0, 1, 4'h2);
      drive();
      run(50, "missing_rlast");
      tick();
      check_int("missing_rlast_err", int'(length_error), 1);
   endtask

   initial begin
      s_if.rready = 1'b0;
      m_if.rvalid = 1'b0;
      cmd_valid   = 1'b0;
      @(negedge ACLK);
      test_reset();
      test_unsplit();
      test_split();
      test_backpressure();
      test_no_cmd();
      test_random();
      test_length_mismatch();
      test_reset_mid();
      test_missing_rlast();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_protocol_converter_r_axi3_merge.md
Name: axi_protocol_converter_r_axi3_merge

Overview:
AXI3-to-AXI4 read-data (R channel) converter. It is the return-path counterpart of the W-channel splitter. The AR path splits one AXI4 burst into several AXI3 bursts of at most 16 beats and pushes one command per AXI3 burst. This block consumes those commands, merges the returning AXI3 R beats back into a single AXI4 burst (suppressing RLAST on non-final splits), checks beat counts, and drives the slave-side R channel through a 2-entry skid buffer.

Parameters:
C_FAMILY, "none", target family string; unused functionally
C_AXI_ID_WIDTH, 1, RID width
C_AXI_DATA_WIDTH, 32, RDATA width (32..1024)
C_AXI_SUPPORTS_USER_SIGNALS, 0, 1 = pass RUSER through; 0 = drive RUSER to zero
C_AXI_RUSER_WIDTH, 1, RUSER width
C_SUPPORT_SPLITTING, 1, 0 = cmd_split ignored, M_AXI_RLAST passed unchanged
C_SUPPORT_BURSTS, 1, 0 = every AXI3 burst is a single beat

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
cmd_valid  in  1  command available for the current AXI3 burst
cmd_split  in  1  1 = more AXI3 bursts follow for the same AXI4 burst
cmd_length  in  4  expected beats minus 1 for this AXI3 burst
cmd_ready  out  1  pops the command; pulses on the accepted M-side last beat
length_error  out  1  sticky flag: beat count differs from cmd_length
S_AXI_RID  out  C_AXI_ID_WIDTH  read ID
S_AXI_RDATA  out  C_AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  merged last
S_AXI_RUSER  out  C_AXI_RUSER_WIDTH  user
S_AXI_RVALID  out  1  valid
S_AXI_RREADY  in  1  ready
M_AXI_RID  in  C_AXI_ID_WIDTH  AXI3 read ID
M_AXI_RDATA  in  C_AXI_DATA_WIDTH  AXI3 read data
M_AXI_RRESP  in  2  AXI3 read response
M_AXI_RLAST  in  1  AXI3 last
M_AXI_RUSER  in  C_AXI_RUSER_WIDTH  AXI3 user
M_AXI_RVALID  in  1  AXI3 valid
M_AXI_RREADY  out  1  AXI3 ready

Behaviour:
- Reset values: S_AXI_RVALID=0, M_AXI_RREADY=0, cmd_ready=0, length_error=0, beat counter=0, both skid entries empty. A reset mid-burst discards buffered beats and the counter immediately.
- M_AXI_RREADY = cmd_valid & ~skid_full & ~ARESET. The beat is accepted (pop) when M_AXI_RVALID & M_AXI_RREADY.
- Transform on pop (combinational, before the buffer):
  - RID, RDATA, RRESP pass through.
  - RUSER passes through, or is forced to 0 when C_AXI_SUPPORTS_USER_SIGNALS=0.
  - S-side last = M_AXI_RLAST & ~cmd_split. When C_SUPPORT_SPLITTING=0, S-side last = M_AXI_RLAST.
- m_last = M_AXI_RLAST when C_SUPPORT_BURSTS=1, else 1.
- cmd_ready = pop & m_last (combinational, single-cycle pulse).
- Skid buffer: an output register plus one skid register.
  - Latency 1 cycle from M-side accept to S_AXI_RVALID when the output register is empty.
  - Full throughput is sustained when S_AXI_RREADY is held at 1.
  - On S stall with output full, the accepted beat goes to skid and M_AXI_RREADY drops the next cycle.
  - Simultaneous S-side drain and M-side pop: output reloads from skid if skid is occupied, else from the incoming beat. Ordering is preserved.
- Beat counter (8 bit, only bits [3:0] compared):
  - Increments on every pop; clears to 0 on pop & m_last.
  - length_error sets on pop & m_last & (counter != cmd_length).
  - length_error also sets on pop & ~M_AXI_RLAST & (counter == cmd_length), i.e. a missing RLAST.
  - length_error clears only on reset.
- Without cmd_valid, no beats are accepted (M_AXI_RREADY=0). Beats are never dropped.
- RRESP is not merged: each beat carries its own response.

Decomposition:
- Shared package axi_protocol_converter_pkg: RRESP encodings (OKAY/EXOKAY/SLVERR/DECERR) and the AXI3 maximum-length constant (16).
- One sub-module: axi_protocol_converter_r_skid, a generic 2-entry valid/ready skid buffer parameterised by payload width. Payload = {RID, RDATA, RRESP, RLAST, RUSER}.

Test Plan:
- Unsplit 4-beat burst: cmd (split=0, length=3), M beats with RLAST on beat 4, S_AXI_RREADY=1.
  -> 4 S beats; RLAST on beat 4 only; cmd_ready pulses once; 1-cycle latency; length_error=0.
- 20-beat AXI4 burst split 16+4: cmds (split=1, length=15) then (split=0, length=3).
  -> 20 S beats; M RLAST on beat 16 is suppressed; S RLAST only on beat 20; cmd_ready pulses on beats 16 and 20.
- Backpressure: S_AXI_RREADY=0 for 5 cycles mid-burst with M_AXI_RVALID=1.
  -> at most 2 beats buffered; M_AXI_RREADY=0 after the skid fills; data order and values intact after release.
- Length mismatch: cmd length=3, M_AXI_RLAST on beat 2.
  -> length_error=1 the next cycle and it stays set; a second, correct burst passes with the flag still 1.
- No command: M_AXI_RVALID=1, cmd_valid=0 for 10 cycles.
  -> M_AXI_RREADY=0 and S_AXI_RVALID=0 throughout; first beat accepted the cycle cmd_valid rises.
- Reset mid-burst after 2 of 4 beats with the buffer full.
  -> S_AXI_RVALID=0, M_AXI_RREADY=0, length_error=0 the next cycle; a new burst completes normally.
